// File: rtl/priority_pkg.sv
// Shared constants and helpers for the priority arbiter.
// Latency: n/a (package). Backpressure: n/a.
// Contents: MODE_FIXED / MODE_RR encodings for rr_mode, wrap_inc() pointer helper.
package priority_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Next index after idx, wrapping n -> 0. Uses an explicit compare rather
  // than a power-of-two mask so that odd requester counts wrap correctly.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    int unsigned nxt;
    nxt = idx + 1;
    return (nxt == n) ? 0 : nxt;
  endfunction

endpackage

// File: rtl/priority_arbiter_if.sv
// Grant handshake bundle between request sources / consumer and the arbiter.
// Latency: n/a (wires only). Backpressure: gnt_ready qualifies gnt_valid.
// Signals: req[N], enable, rr_mode, gnt_ready (towards arbiter); gnt_valid, gnt_idx, gnt_onehot (from arbiter).
interface priority_arbiter_if #(
  parameter int N = 8
);
  localparam int IDX_W = $clog2(N);

  logic [N-1:0]     req;
  logic             enable;
  logic             rr_mode;
  logic             gnt_ready;
  logic             gnt_valid;
  logic [IDX_W-1:0] gnt_idx;
  logic [N-1:0]     gnt_onehot;

  // master: request sources plus the grant consumer
  modport master (
    output req, enable, rr_mode, gnt_ready,
    input  gnt_valid, gnt_idx, gnt_onehot
  );

  // slave: the arbiter itself
  modport slave (
    input  req, enable, rr_mode, gnt_ready,
    output gnt_valid, gnt_idx, gnt_onehot
  );

endinterface

// File: rtl/priority_arbiter_pick.sv
// Combinational winner search: first set req bit at or after start, wrapping N-1 -> 0.
// Latency: 0 cycles (pure combinational). Backpressure: none.
// Ports: req[N], start[IDX_W], rr in; idx[IDX_W], found out. rr=0 forces start=0 (lowest index wins).
module prio_pick #(
  parameter int N = 8
) (
  input  logic [N-1:0]            req,
  input  logic [$clog2(N)-1:0]    start,
  input  logic                    rr,
  output logic [$clog2(N)-1:0]    idx,
  output logic                    found
);
  import priority_pkg::*;

  localparam int IDX_W = $clog2(N);

  // The request vector is laid out twice so a wrapping search becomes a
  // linear scan over the window [s, s+N) of the doubled vector.
  logic [2*N-1:0] dbl;
  assign dbl = {req, req};

  always_comb begin
    int s;
    idx   = '0;
    found = 1'b0;
    s     = (rr == MODE_RR) ? int'(start) : 0;
    for (int i = 0; i < 2*N; i++) begin
      if (!found && dbl[i] && (i >= s) && (i < s + N)) begin
        found = 1'b1;
        if (i >= N) idx = IDX_W'(i - N);
        else        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/priority_arbiter.sv
// Registered N-way arbiter: fixed-priority or round-robin grant with valid/ready handshake.
// Latency: 1 cycle from req sample to grant outputs; no combinational req -> output path.
// Backpressure: grant held frozen while gnt_ready=0; accept with capture gives 1 grant/cycle.
// Ports: clk, rst (sync, active-high); bus (slave modport of priority_arbiter_if).
module priority_arbiter #(
  parameter int N = 8
) (
  input  logic               clk,
  input  logic               rst,
  priority_arbiter_if.slave  bus
);
  import priority_pkg::*;

  localparam int IDX_W = $clog2(N);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]       state;
  logic [IDX_W-1:0] gnt_idx_q;
  logic [N-1:0]     gnt_onehot_q;
  logic [IDX_W-1:0] ptr;

  logic             accept;
  logic             capture;
  logic [IDX_W-1:0] after_gnt;
  logic [IDX_W-1:0] start;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic [N-1:0]     pick_oh;

  assign accept    = (state == HOLD) && bus.gnt_ready;
  assign after_gnt = IDX_W'(wrap_inc(32'(gnt_idx_q), N));

  // On an accept the search begins just past the index being retired, so a
  // back-to-back capture cannot hand the same requester a second grant while
  // someone else is waiting (ptr only updates at the same edge).
  assign start = accept ? after_gnt : ptr;

  prio_pick #(.N(N)) u_pick (
    .req   (bus.req),
    .start (start),
    .rr    (bus.rr_mode),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // pick_found is exactly |req: the scan window always covers all N bits.
  assign capture = bus.enable && pick_found && ((state == IDLE) || accept);
  assign pick_oh = {{(N-1){1'b0}}, 1'b1} << pick_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      gnt_idx_q    <= '0;
      gnt_onehot_q <= '0;
      ptr          <= '0;
    end else begin
      if (accept) begin
        ptr <= after_gnt;
      end
      if (capture) begin
        state        <= HOLD;
        gnt_idx_q    <= pick_idx;
        gnt_onehot_q <= pick_oh;
      end else if (accept) begin
        // gnt_idx keeps its last value; only valid/onehot are cleared
        state        <= IDLE;
        gnt_onehot_q <= '0;
      end
    end
  end

  assign bus.gnt_valid  = (state == HOLD);
  assign bus.gnt_idx    = gnt_idx_q;
  assign bus.gnt_onehot = gnt_onehot_q;

endmodule

// File: tb/tb_priority_arbiter.sv
// Directed self-checking bench for priority_arbiter at N=8 and N=5.
// Inputs driven 1 time unit after the rising edge; outputs sampled at the same point.
// Expected values are hand-computed constants per scenario.
module tb_priority_arbiter;

  logic clk = 1'b0;
  logic rst8;
  logic rst5;

  always #5 clk = ~clk;

  priority_arbiter_if #(.N(8)) b8 ();
  priority_arbiter_if #(.N(5)) b5 ();

  priority_arbiter #(.N(8)) dut8 (.clk(clk), .rst(rst8), .bus(b8));
  priority_arbiter #(.N(5)) dut5 (.clk(clk), .rst(rst5), .bus(b5));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset8();
    rst8 = 1'b1;
    step();
    rst8 = 1'b0;
  endtask

  initial begin
    int exp_idx;

    rst8 = 1'b1; rst5 = 1'b1;
    b8.req = '0; b8.enable = 1'b0; b8.rr_mode = 1'b0; b8.gnt_ready = 1'b0;
    b5.req = '0; b5.enable = 1'b0; b5.rr_mode = 1'b0; b5.gnt_ready = 1'b0;
    step();
    step();

    // Reset state
    check("rst_valid",  32'(b8.gnt_valid),  32'd0);
    check("rst_idx",    32'(b8.gnt_idx),    32'd0);
    check("rst_onehot", 32'(b8.gnt_onehot), 32'd0);
    rst8 = 1'b0;

    // Fixed capture
    b8.rr_mode = 1'b0; b8.enable = 1'b1; b8.gnt_ready = 1'b1; b8.req = 8'b1010_0000;
    step();
    check("fix_valid",  32'(b8.gnt_valid),  32'd1);
    check("fix_idx",    32'(b8.gnt_idx),    32'd5);
    check("fix_onehot", 32'(b8.gnt_onehot), 32'h20);

    // Fixed starvation: index 2 never wins
    b8.req = 8'b0000_0110;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("starve_idx%0d", k),   32'(b8.gnt_idx),   32'd1);
      check($sformatf("starve_valid%0d", k), 32'(b8.gnt_valid), 32'd1);
    end

    // RR sweep 0..7,0 back-to-back
    b8.req = '0;
    reset8();
    b8.rr_mode = 1'b1; b8.enable = 1'b1; b8.gnt_ready = 1'b1; b8.req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      step();
      exp_idx = k % 8;
      check($sformatf("rr_idx%0d", k),    32'(b8.gnt_idx),    32'(exp_idx));
      check($sformatf("rr_valid%0d", k),  32'(b8.gnt_valid),  32'd1);
      check($sformatf("rr_onehot%0d", k), 32'(b8.gnt_onehot), 32'(1) << exp_idx);
    end

    // Backpressure: grant frozen even when req drops
    b8.req = '0;
    reset8();
    b8.rr_mode = 1'b1; b8.enable = 1'b1; b8.gnt_ready = 1'b0; b8.req = 8'b0000_1001;
    step();
    check("bp_cap_idx", 32'(b8.gnt_idx), 32'd0);
    for (int k = 0; k < 3; k++) begin
      if (k == 1) b8.req = '0;
      step();
      check($sformatf("bp_hold_idx%0d", k),   32'(b8.gnt_idx),   32'd0);
      check($sformatf("bp_hold_valid%0d", k), 32'(b8.gnt_valid), 32'd1);
    end
    b8.req = 8'b0000_1001; b8.gnt_ready = 1'b1;
    step();
    check("bp_next_idx",    32'(b8.gnt_idx),    32'd3);
    check("bp_next_onehot", 32'(b8.gnt_onehot), 32'h08);

    // Enable gating
    b8.req = '0;
    reset8();
    b8.enable = 1'b0; b8.rr_mode = 1'b0; b8.gnt_ready = 1'b1; b8.req = 8'hFF;
    step();
    step();
    check("en_off_valid", 32'(b8.gnt_valid), 32'd0);
    b8.enable = 1'b1; b8.gnt_ready = 1'b0; b8.req = 8'b0100_0000;
    step();
    check("en_cap_idx", 32'(b8.gnt_idx), 32'd6);
    b8.enable = 1'b0; b8.req = 8'hFF;
    step();
    check("en_hold_valid", 32'(b8.gnt_valid), 32'd1);
    check("en_hold_idx",   32'(b8.gnt_idx),   32'd6);
    b8.gnt_ready = 1'b1;
    step();
    check("en_drain_valid",  32'(b8.gnt_valid),  32'd0);
    check("en_drain_onehot", 32'(b8.gnt_onehot), 32'd0);

    // Pointer survives a mode change: last accept was idx 6 -> ptr=7
    b8.enable = 1'b1; b8.rr_mode = 1'b1; b8.gnt_ready = 1'b0; b8.req = 8'b1000_0001;
    step();
    check("mode_sw_idx", 32'(b8.gnt_idx), 32'd7);

    // Odd N=5 round-robin with mid-grant reset
    rst5 = 1'b0;
    b5.rr_mode = 1'b1; b5.enable = 1'b1; b5.gnt_ready = 1'b1; b5.req = 5'b10001;
    for (int k = 0; k < 4; k++) begin
      step();
      exp_idx = (k % 2 == 0) ? 0 : 4;
      check($sformatf("n5_idx%0d", k), 32'(b5.gnt_idx), 32'(exp_idx));
    end
    check("n5_pre_rst_valid", 32'(b5.gnt_valid), 32'd1);
    rst5 = 1'b1;
    step();
    check("n5_rst_valid", 32'(b5.gnt_valid), 32'd0);
    check("n5_rst_idx",   32'(b5.gnt_idx),   32'd0);
    rst5 = 1'b0;
    step();
    check("n5_post_valid", 32'(b5.gnt_valid), 32'd1);
    check("n5_post_idx",   32'(b5.gnt_idx),   32'd0);
    step();
    check("n5_post_idx2",  32'(b5.gnt_idx),   32'd4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
